// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 set-2 scan-code parser.
// Pure declarations: no logic, no latency, no flow control.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Controller replies (ACK, BAT, echo, resend, error) and Pause lead-in carry no key meaning.
  localparam int PS2_N_DISCARD = 7;
  localparam logic [PS2_N_DISCARD*8-1:0] PS2_DISCARD =
    {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  typedef struct packed {
    logic       rep;
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } ps2_ev_t;

  function automatic logic ps2_is_discard(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < PS2_N_DISCARD; i++) begin
      if (PS2_DISCARD[i*8 +: 8] == b) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// Byte-in / event-out bundle of the PS/2 key controller.
// master = byte source + event consumer; slave = the controller.
interface ps2_key_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       ev_repeat;

  modport master (
    output rx_valid, rx_data, ev_ready,
    input  ev_valid, ev_code, ev_ext, ev_break, ev_repeat
  );

  modport slave (
    input  rx_valid, rx_data, ev_ready,
    output ev_valid, ev_code, ev_ext, ev_break, ev_repeat
  );
endinterface

// File: rtl/ps2_ev_fifo.sv
// Generic synchronous FIFO; write visible at dout the cycle after push, pop shows next entry next cycle.
// A push when full is accepted only if a pop happens in the same cycle; otherwise it is ignored.
module ps2_ev_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 11,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign level = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once count says they were written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// Parses PS/2 set-2 bytes (E0/F0 prefixes) into key events, tracks held key and press count.
// Final byte at edge N is visible from cycle N+1; no backpressure to the receiver, events dropped when FIFO full.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter  int FIFO_DEPTH = 8,
  parameter  int CNT_W      = 8,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  ps2_key_ctrl_if.slave    bus,
  output logic [7:0]       held_code,
  output logic             held_ext,
  output logic             key_down,
  output logic [CNT_W-1:0] press_cnt,
  output logic             overflow,
  output logic [LW-1:0]    fifo_level
);

  ps2_state_e       state_q, state_d;
  logic [7:0]       held_code_q, held_code_d;
  logic             held_ext_q, held_ext_d;
  logic             key_down_q, key_down_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic             overflow_q, overflow_d;

  logic    do_make, do_brk, is_ext, key_match;
  logic    push, pop, full, empty;
  ps2_ev_t ev_in, ev_head;

  always_comb begin
    state_d     = state_q;
    held_code_d = held_code_q;
    held_ext_d  = held_ext_q;
    key_down_d  = key_down_q;
    press_cnt_d = press_cnt_q;
    overflow_d  = overflow_q;
    do_make     = 1'b0;
    do_brk      = 1'b0;
    is_ext      = 1'b0;

    if (bus.rx_valid) begin
      unique case (state_q)
        IDLE: begin
          if (bus.rx_data == PS2_EXT)      state_d = EXT;
          else if (bus.rx_data == PS2_BRK) state_d = BRK;
          else if (!ps2_is_discard(bus.rx_data)) do_make = 1'b1;
        end
        EXT: begin
          is_ext = 1'b1;
          if (bus.rx_data == PS2_BRK)      state_d = EXT_BRK;
          else if (bus.rx_data != PS2_EXT) begin
            do_make = 1'b1;
            state_d = IDLE;
          end
        end
        BRK: begin
          if (bus.rx_data == PS2_EXT)      state_d = EXT_BRK;
          else if (bus.rx_data != PS2_BRK) begin
            do_brk  = 1'b1;
            state_d = IDLE;
          end
        end
        EXT_BRK: begin
          is_ext = 1'b1;
          if (bus.rx_data != PS2_EXT && bus.rx_data != PS2_BRK) begin
            do_brk  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    key_match  = (held_ext_q == is_ext) && (held_code_q == bus.rx_data);
    ev_in      = '0;
    ev_in.code = bus.rx_data;
    ev_in.ext  = is_ext;
    ev_in.brk  = do_brk;

    if (do_make) begin
      ev_in.rep = key_down_q && key_match;
      if (!ev_in.rep) press_cnt_d = press_cnt_q + CNT_W'(1);
      held_code_d = bus.rx_data;
      held_ext_d  = is_ext;
      key_down_d  = 1'b1;
    end
    // A release of some other key leaves the held key untouched.
    if (do_brk && key_match) key_down_d = 1'b0;

    push = do_make || do_brk;
    pop  = !empty && bus.ev_ready;
    if (push && full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      held_code_q <= '0;
      held_ext_q  <= 1'b0;
      key_down_q  <= 1'b0;
      press_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      held_code_q <= held_code_d;
      held_ext_q  <= held_ext_d;
      key_down_q  <= key_down_d;
      press_cnt_q <= press_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  ps2_ev_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(ps2_ev_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (ev_in),
    .pop   (pop),
    .dout  (ev_head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign bus.ev_valid  = !empty;
  assign bus.ev_code   = ev_head.code;
  assign bus.ev_ext    = ev_head.ext;
  assign bus.ev_break  = ev_head.brk;
  assign bus.ev_repeat = ev_head.rep;

  assign held_code = held_code_q;
  assign held_ext  = held_ext_q;
  assign key_down  = key_down_q;
  assign press_cnt = press_cnt_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed and random byte streams into ps2_key_ctrl, checked against a prefix-flag/queue model.
module tb_ps2_key_ctrl;
  import ps2_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ps2_key_ctrl_if bus ();

  logic [7:0]       held_code;
  logic             held_ext, key_down, overflow;
  logic [CNT_W-1:0] press_cnt;
  logic [LW-1:0]    fifo_level;

  ps2_key_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .held_code  (held_code),
    .held_ext   (held_ext),
    .key_down   (key_down),
    .press_cnt  (press_cnt),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  // Reference model: pending-prefix flags plus a bounded event queue.
  ps2_ev_t    mq[$];
  logic [7:0] m_held_code;
  logic       m_held_ext, m_key_down, m_ovf;
  int         m_cnt;
  bit         pend_ext, pend_brk;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit discard_byte(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_held_code = 8'h00;
    m_held_ext  = 1'b0;
    m_key_down  = 1'b0;
    m_ovf       = 1'b0;
    m_cnt       = 0;
    pend_ext    = 1'b0;
    pend_brk    = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    ps2_ev_t e;
    bool_same: begin end
    if (!pend_ext && !pend_brk && discard_byte(b)) return;
    if (b == 8'hE0) begin
      pend_ext = 1'b1;
    end else if (b == 8'hF0) begin
      pend_brk = 1'b1;
    end else begin
      e.code = b;
      e.ext  = pend_ext;
      e.brk  = pend_brk;
      e.rep  = 1'b0;
      if (!pend_brk) begin
        e.rep = m_key_down && (m_held_ext == pend_ext) && (m_held_code == b);
        if (!e.rep) m_cnt = (m_cnt + 1) % (1 << CNT_W);
        m_held_code = b;
        m_held_ext  = pend_ext;
        m_key_down  = 1'b1;
      end else if ((m_held_ext == pend_ext) && (m_held_code == b)) begin
        m_key_down = 1'b0;
      end
      if (mq.size() < DEPTH) mq.push_back(e);
      else m_ovf = 1'b1;
      pend_ext = 1'b0;
      pend_brk = 1'b0;
    end
  endtask

  task automatic check_status();
    chk("fifo_level", 32'(fifo_level), mq.size());
    chk("held_code", 32'(held_code), 32'(m_held_code));
    chk("held_ext", 32'(held_ext), 32'(m_held_ext));
    chk("key_down", 32'(key_down), 32'(m_key_down));
    chk("press_cnt", 32'(press_cnt), m_cnt);
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // Called just after an active edge; drives one cycle and checks head mid-cycle, status after the edge.
  task automatic step(input logic v, input logic [7:0] b, input logic r);
    bus.rx_valid = v;
    bus.rx_data  = b;
    bus.ev_ready = r;
    #3;
    chk("ev_valid", 32'(bus.ev_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("ev_code", 32'(bus.ev_code), 32'(mq[0].code));
      chk("ev_ext", 32'(bus.ev_ext), 32'(mq[0].ext));
      chk("ev_break", 32'(bus.ev_break), 32'(mq[0].brk));
      chk("ev_repeat", 32'(bus.ev_repeat), 32'(mq[0].rep));
      if (r) void'(mq.pop_front());
    end
    if (v) model_byte(b);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.ev_ready = 1'b0;
    check_status();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (mq.size() > 0) step(1'b0, 8'h00, 1'b1);
    end
    chk("drain_level", 32'(fifo_level), 0);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.ev_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk("rst_ev_valid", 32'(bus.ev_valid), 0);
    check_status();
  endtask

  initial begin
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.ev_ready = 1'b0;
    model_reset();
    @(posedge clk);
    do_reset();

    // Plain make then break
    step(1, 8'h1C, 0); step(1, 8'hF0, 0); step(1, 8'h1C, 0);
    drain();
    chk("tp1_cnt", 32'(press_cnt), 1);
    chk("tp1_down", 32'(key_down), 0);

    // Extended make/break, consumer always ready
    step(1, 8'hE0, 1); step(1, 8'h75, 1);
    chk("tp2_held_ext", 32'(held_ext), 1);
    step(1, 8'hE0, 1); step(1, 8'hF0, 1); step(1, 8'h75, 1);
    drain();

    // Typematic repeats
    do_reset();
    step(1, 8'h1C, 0); step(1, 8'h1C, 0); step(1, 8'h1C, 0);
    step(1, 8'hF0, 0); step(1, 8'h1C, 0);
    drain();
    chk("tp3_cnt", 32'(press_cnt), 1);

    // Release of a non-held key
    do_reset();
    step(1, 8'h1C, 0); step(1, 8'h32, 0); step(1, 8'hF0, 0); step(1, 8'h1C, 0);
    drain();
    chk("tp4_down", 32'(key_down), 1);
    chk("tp4_held", 32'(held_code), 32'h32);
    chk("tp4_cnt", 32'(press_cnt), 2);

    // Overflow with a stalled consumer
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) step(1, 8'(8'h10 + i), 0);
    chk("tp5_level", 32'(fifo_level), DEPTH);
    chk("tp5_ovf", 32'(overflow), 1);
    chk("tp5_cnt", 32'(press_cnt), DEPTH + 2);
    drain();
    // Full FIFO with a simultaneous pop still accepts the push
    for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h30 + i), 0);
    step(1, 8'h50, 1);
    chk("tp5_full_pop", 32'(fifo_level), DEPTH);
    drain();

    // Reset discards a pending E0 prefix
    do_reset();
    step(1, 8'hE0, 0);
    do_reset();
    step(1, 8'h1C, 0);
    drain();

    // Controller replies produce no events
    do_reset();
    step(1, 8'hAA, 0); step(1, 8'hFA, 0);
    chk("tp7_level", 32'(fifo_level), 0);
    step(1, 8'h1C, 0);
    drain();

    // Random streams with random consumer readiness
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [7:0] b;
      case ($urandom_range(0, 9))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        2:       b = 8'h1C;
        3:       b = 8'h32;
        4:       b = 8'hAA;
        5:       b = 8'h75;
        6:       b = 8'hFA;
        default: b = 8'($urandom_range(0, 255));
      endcase
      step(logic'($urandom_range(0, 3) != 0), b, logic'($urandom_range(0, 2) == 0));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_key_ctrl.md
# ps2_key_ctrl

- Sits behind the PS/2 byte receiver and turns its raw scan-code byte stream (set 2) into key events.
- Parses 0xE0 (extended) and 0xF0 (break) prefixes and tracks the currently held key and its typematic repeats.
- Counts distinct key presses and buffers events in a small FIFO drained by a valid/ready consumer (CPU-side MMIO register or display logic).

## Interface
Parameters:
- FIFO_DEPTH, 8: event FIFO entries; power of two, ≥2.
- CNT_W, 8: width of the press counter.

Ports:
- clk  in  1  system clock; every register samples on its rising edge.
- reset  in  1  synchronous, active-high; takes effect on the clk edge where it is sampled high.
- rx_valid  in  1  one-cycle strobe: rx_data holds a checked byte from the receiver.
- rx_data  in  8  received scan-code byte.
- ev_valid  out  1  FIFO head is valid.
- ev_ready  in  1  consumer accepts the head; a pop occurs when ev_valid && ev_ready.
- ev_code  out  8  head event: key code, prefixes stripped.
- ev_ext  out  1  head event: key was 0xE0-prefixed.
- ev_break  out  1  head event: release (1) or press (0).
- ev_repeat  out  1  head event: typematic repeat of the already-held key.
- held_code  out  8  code of the key last pressed.
- held_ext  out  1  ext flag of that key.
- key_down  out  1  held key not yet released.
- press_cnt  out  CNT_W  count of non-repeat presses; wraps.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
The FSM advances only on cycles with rx_valid=1. B denotes rx_data.

**IDLE**
- B=0xE0 → EXT.
- B=0xF0 → BRK.
- B ∈ {0x00, 0xAA, 0xE1, 0xEE, 0xFA, 0xFE, 0xFF} → discarded; stay IDLE.
- Any other B → make event (ext=0, code=B); stay IDLE.

**EXT**
- B=0xF0 → EXT_BRK.
- B=0xE0 → stay EXT.
- Other B → make event (ext=1, code=B) → IDLE.

**BRK**
- B=0xE0 → EXT_BRK.
- B=0xF0 → stay BRK.
- Other B → break event (ext=0) → IDLE.

**EXT_BRK**
- B ∈ {0xE0, 0xF0} → stay EXT_BRK.
- Other B → break event (ext=1) → IDLE.

**Make event**
- repeat = key_down && {held_ext, held_code} == {ext, code}.
- If not repeat: press_cnt += 1, modulo 2^CNT_W.
- Always: held_code, held_ext ← event values; key_down ← 1.

**Break event**
- key_down ← 0 only if {ext, code} matches the held key.
- Otherwise the held state is unchanged.
- repeat = 0.

**FIFO**
- Every event is pushed.
- Full with no pop in the same cycle: the event is dropped and overflow ← 1. The held state and press_cnt still update.
- Full with a pop in the same cycle: the push is accepted; occupancy stays FIFO_DEPTH.
- Empty: ev_valid=0. ev_code, ev_ext, ev_break and ev_repeat are don't-care.
- The ev_* fields are stable while ev_valid && !ev_ready.

## Timing
- Reset values:
  - FSM: IDLE.
  - FIFO: empty, so ev_valid=0 and fifo_level=0.
  - held_code=0, held_ext=0, key_down=0, press_cnt=0, overflow=0.
- Reset mid-sequence (e.g. after 0xE0) discards the pending prefix; the next byte is parsed from IDLE.
- Latency: the final byte strobed at edge N is written at edge N. ev_valid, fifo_level, held_* and press_cnt reflect it from cycle N+1.
- Consumption: a pop at edge N presents the next entry in cycle N+1.
- Back-to-back rx_valid on consecutive cycles is supported with one byte per cycle, with no stall.
- There is no backpressure to the receiver; ev_ready never affects parsing.
- overflow clears only on reset.

## Structure
- Package ps2_pkg holds:
  - State enum {IDLE, EXT, BRK, EXT_BRK}.
  - Constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
  - The discard-code list.
  - ps2_ev_t packed struct {repeat, brk, ext, code[7:0]}, 11 bits.
- Submodule ps2_ev_fifo: synchronous FIFO parameterised by depth and width.
  - Ports: push, pop, full, empty, level.
  - Same-cycle push/pop allowed when full or empty.
  - Width is $bits(ps2_ev_t).
- Parser FSM and held-key/counter logic live in the top module.

## Test plan
- Bytes 1C, F0 1C, idle ready=1:
  - Event {code 1C, ext 0, brk 0, rep 0}, then {1C, 0, 1, 0}.
  - press_cnt=1, key_down=0.
- Bytes E0 75, E0 F0 75:
  - Events {75, ext 1, make} and {75, ext 1, break}.
  - held_ext=1 after the first event.
- Typematic 1C 1C 1C then F0 1C:
  - Events carry rep 0, 1, 1, then a break.
  - press_cnt=1.
- Bytes 1C, 32, F0 1C:
  - key_down=1 with held_code=32 after the break.
  - press_cnt=2.
- ev_ready=0, FIFO_DEPTH+2 makes of distinct codes:
  - fifo_level=FIFO_DEPTH, overflow=1.
  - Draining returns the first FIFO_DEPTH codes in order.
  - press_cnt=FIFO_DEPTH+2.
- Reset asserted after E0:
  - All outputs return to reset values.
  - The next byte 1C yields ext=0.
- Bytes AA, FA:
  - No events, FSM stays IDLE.
